bit2sy: RTL and testbench
=========================

// Module: bit2sy
// PURPOSE
//  Serial-bit to constellation-symbol packer; TX-side counterpart of the RX symbol-to-bit unpacker.
//  Accepts one data bit per slave handshake and packs 4 bits (16-QAM) or 2 bits (QPSK), LSB first.
//  Presents packed symbols on a registered master port to the mapper, which feeds the IFFT.
// PARAMETERS
//  SLOTS      52       output slots per OFDM symbol (data + pilot)
//  PILOT_VAL  4'b0011  symbol value driven in pilot slots (PILOT_INSERT_EN only)
// PORTS
//  CLK_I   in   1  system clock, single clock domain
//  RST_I   in   1  reset, asynchronous, active-high
//  CYC_I   in   1  slave burst valid
//  STB_I   in   1  slave strobe
//  WE_I    in   1  slave write enable
//  DAT_I   in   1  serial data bit
//  ACK_O   out  1  bit accepted this cycle
//  QAM     in   1  16-QAM mode (4 bits/symbol); wins over QPSK
//  QPSK    in   1  QPSK mode (2 bits/symbol)
//  CYC_O   out  1  master burst valid
//  STB_O   out  1  master strobe, symbol valid
//  WE_O    out  1  equals STB_O
//  DAT_O   out  4  packed symbol; QPSK uses [1:0], [3:2]=0
//  ACK_I   in   1  downstream accepted symbol
//  SYM_END out  1  one-cycle pulse when slot SLOTS-1 is accepted
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; bit_cnt=0, slot_cnt=0, shift reg=0.
//  ena = CYC_I & STB_I & WE_I; out_halt = STB_O & ~ACK_I.
//  ACK_O = ena & (state==ACCUM) & ~hold_full & mode_ok; combinational; mode_ok = latched QAM|QPSK.
//  Mode (BPS=4 or 2) latched on CYC_I rising edge; mode pins ignored mid-burst.
//  Both QAM and QPSK low at burst start: ACK_O stays 0, no output.
//  Bit k of a symbol (k=0 first accepted) lands in DAT_O[k].
//  States:
//   IDLE  : wait CYC_I; on CYC_I go ACCUM, clear bit_cnt/slot_cnt.
//   ACCUM : each ACK_O shifts bit in, bit_cnt++; at bit_cnt==BPS-1 with ACK_O, symbol complete:
//           if output reg free (~STB_O | ACK_I) load DAT_O, STB_O=1 next cycle; else store in hold reg
//           (hold_full) and stop acking until drained. Latency: last bit accepted -> STB_O 1 cycle.
//   PILOT : (macro only) slot_cnt is pilot slot; load PILOT_VAL when output free, no ACK_O.
//   FLUSH : CYC_I fell with bit_cnt!=0: zero-pad remaining bits, emit partial symbol, then DRAIN.
//   DRAIN : wait until STB_O=0 and hold empty; drop CYC_O; go IDLE.
//  STB_O/DAT_O held stable while out_halt; STB_O drops on ACK_I with nothing queued.
//  CYC_O rises with first STB_O of burst, falls in DRAIN exit cycle.
//  slot_cnt increments on every accepted output (ACK_I & STB_O), wraps SLOTS-1 -> 0 with SYM_END.
//  Simultaneous symbol completion and ACK_I: new symbol loads directly, no bubble.
//  CYC_I re-asserted during DRAIN: ignored until IDLE reached.
//  Async reset mid-burst: partial symbol and hold reg discarded; STB_O/CYC_O drop immediately.
// CONFIGURATION
//  PILOT_INSERT_EN defined: slots 5,19,32,46 carry PILOT_VAL; input stalled (ACK_O=0) for those slots;
//   48 data symbols per 52 slots.
//  Not defined: every slot carries data; PILOT state unreachable; SLOTS only drives SYM_END.
// STRUCTURE
//  Shared package/header: BPS_QAM=4, BPS_QPSK=2, state encodings, pilot slot indices.
//  Sub-module bit2sy_slot_ctr: slot counter, wrap, SYM_END, pilot-slot decode.
//  Packer, hold reg, FSM in top level.
// TESTING
//  QAM, bits 1,0,1,1 with ACK_I=1 -> DAT_O=4'b1101, STB_O 1 cycle after 4th ACK_O.
//  QPSK, bits 1,0,0,1 -> DAT_O=4'b0001 then 4'b0010; DAT_O[3:2]=0 throughout.
//  QAM, ACK_I=0 for 10 cycles with continuous input -> one symbol on DAT_O, one in hold, ACK_O=0; release -> both, in order.
//  QAM, CYC_I drops after 6 bits (1,1,1,1,1,1) -> DAT_O 4'b1111 then 4'b0011; CYC_O falls after last ACK_I.
//  PILOT_INSERT_EN, QAM, 192 bits -> 52 outputs, slots 5/19/32/46 = 4'b0011, SYM_END on 52nd accept.
//  RST_I pulsed after 3 QAM bits -> STB_O=CYC_O=0 at once; next burst first symbol uses only new bits.

Source files
------------

// File: rtl/bit2sy_pkg.sv
// Shared definitions for the bit2sy serial-bit to constellation-symbol packer:
// bits per symbol, FSM encoding and pilot slot positions.
package bit2sy_pkg;

    localparam int unsigned BPS_QAM  = 4;
    localparam int unsigned BPS_QPSK = 2;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAccum = 3'd1,
        StPilot = 3'd2,
        StFlush = 3'd3,
        StDrain = 3'd4
    } state_t;

    localparam int unsigned PILOT_SLOT_0 = 5;
    localparam int unsigned PILOT_SLOT_1 = 19;
    localparam int unsigned PILOT_SLOT_2 = 32;
    localparam int unsigned PILOT_SLOT_3 = 46;

    function automatic logic is_pilot_slot(input int unsigned slot);
        return (slot == PILOT_SLOT_0) || (slot == PILOT_SLOT_1) ||
               (slot == PILOT_SLOT_2) || (slot == PILOT_SLOT_3);
    endfunction

endpackage

// File: rtl/bit2sy_slot_ctr.sv
// Output slot counter for bit2sy: counts accepted symbols, flags the last slot (SYM_END)
// and, when PILOT_INSERT_EN is defined, decodes whether the next issued slot is a pilot.
module bit2sy_slot_ctr
    import bit2sy_pkg::*;
#(
    parameter int unsigned SLOTS = 52
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic accept,
    input  logic commit,
    output logic sym_end,
    output logic pilot_next
);

    localparam int unsigned W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [W-1:0] LAST = W'(SLOTS - 1);

    logic [W-1:0] slot_q;

    assign sym_end = accept & (slot_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else if (clr) begin
            slot_q <= '0;
        end else if (accept) begin
            slot_q <= sym_end ? '0 : slot_q + W'(1);
        end
    end

`ifdef PILOT_INSERT_EN
    // Issue counter runs ahead of slot_q by whatever sits in the output/hold registers.
    logic [W-1:0] issue_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q <= '0;
        end else if (clr) begin
            issue_q <= '0;
        end else if (commit) begin
            issue_q <= (issue_q == LAST) ? '0 : issue_q + W'(1);
        end
    end

    assign pilot_next = is_pilot_slot(32'(issue_q));
`else
    logic unused_commit;
    assign unused_commit = commit;
    assign pilot_next    = 1'b0;
`endif

endmodule

// File: rtl/bit2sy.sv
// Serial-bit to 16-QAM/QPSK symbol packer with one-deep hold register.
// Pilot insertion in slots 5/19/32/46 is enabled by defining PILOT_INSERT_EN.
module bit2sy
    import bit2sy_pkg::*;
#(
    parameter int unsigned SLOTS     = 52,
    parameter logic [3:0]  PILOT_VAL = 4'b0011
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       CYC_I,
    input  logic       STB_I,
    input  logic       WE_I,
    input  logic       DAT_I,
    output logic       ACK_O,
    input  logic       QAM,
    input  logic       QPSK,
    output logic       CYC_O,
    output logic       STB_O,
    output logic       WE_O,
    output logic [3:0] DAT_O,
    input  logic       ACK_I,
    output logic       SYM_END
);

    state_t     state_q, state_d;
    logic       qam_q, mode_ok_q;
    logic [1:0] bit_cnt_q;
    logic [3:0] sh_q, hold_q, dat_q;
    logic       hold_full_q, stb_q, cyc_q;

    logic       ena, out_free, accept, last_bit, burst_start, pilot_next;
    logic       sym_done, commit, load_out, drain_exit;
    logic [3:0] sym_val, commit_val;

    assign ena         = CYC_I & STB_I & WE_I;
    assign out_free    = ~stb_q | ACK_I;
    assign accept      = stb_q & ACK_I;
    assign burst_start = (state_q == StIdle) & CYC_I;
    assign last_bit    = bit_cnt_q == (qam_q ? 2'(BPS_QAM - 1) : 2'(BPS_QPSK - 1));
    assign sym_val     = sh_q | (4'(DAT_I) << bit_cnt_q);
    assign load_out    = out_free & (hold_full_q | commit);
    assign drain_exit  = (state_q == StDrain) & (state_d == StIdle);

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (CYC_I) state_d = StAccum;
            StAccum: begin
                if (!CYC_I)                              state_d = (bit_cnt_q != 2'd0) ? StFlush
                                                                                        : StDrain;
                else if (pilot_next && bit_cnt_q == 2'd0) state_d = StPilot;
            end
            StPilot: if (out_free && !hold_full_q) state_d = StAccum;
            StFlush: if (!hold_full_q)             state_d = StDrain;
            StDrain: if (!stb_q && !hold_full_q)   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ACK_O      = ena & (state_q == StAccum) & ~hold_full_q & mode_ok_q
                     & ~(pilot_next & (bit_cnt_q == 2'd0));
        sym_done   = ACK_O & last_bit;
        commit     = 1'b0;
        commit_val = sym_val;
        unique case (state_q)
            StAccum: commit = sym_done;
            StPilot: begin
                // Pilot goes straight to the output so it never overtakes a held symbol.
                commit     = out_free & ~hold_full_q;
                commit_val = PILOT_VAL;
            end
            StFlush: begin
                commit     = ~hold_full_q;
                commit_val = sh_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            qam_q       <= 1'b0;
            mode_ok_q   <= 1'b0;
            bit_cnt_q   <= 2'd0;
            sh_q        <= 4'd0;
            hold_q      <= 4'd0;
            hold_full_q <= 1'b0;
            dat_q       <= 4'd0;
            stb_q       <= 1'b0;
            cyc_q       <= 1'b0;
        end else begin
            if (burst_start) begin
                qam_q     <= QAM;
                mode_ok_q <= QAM | QPSK;
                bit_cnt_q <= 2'd0;
                sh_q      <= 4'd0;
            end else if (ACK_O) begin
                bit_cnt_q <= last_bit ? 2'd0 : bit_cnt_q + 2'd1;
                sh_q      <= last_bit ? 4'd0 : sym_val;
            end else if (state_q == StFlush && commit) begin
                bit_cnt_q <= 2'd0;
                sh_q      <= 4'd0;
            end

            if (out_free) begin
                if (hold_full_q) begin
                    dat_q       <= hold_q;
                    stb_q       <= 1'b1;
                    hold_full_q <= 1'b0;
                end else if (commit) begin
                    dat_q <= commit_val;
                    stb_q <= 1'b1;
                end else begin
                    stb_q <= 1'b0;
                end
            end else if (commit) begin
                hold_q      <= commit_val;
                hold_full_q <= 1'b1;
            end

            if (drain_exit)    cyc_q <= 1'b0;
            else if (load_out) cyc_q <= 1'b1;
        end
    end

    bit2sy_slot_ctr #(
        .SLOTS (SLOTS)
    ) u_slot_ctr (
        .clk        (CLK_I),
        .rst        (RST_I),
        .clr        (burst_start),
        .accept     (accept),
        .commit     (commit),
        .sym_end    (SYM_END),
        .pilot_next (pilot_next)
    );

    assign STB_O = stb_q;
    assign WE_O  = stb_q;
    assign CYC_O = cyc_q;
    assign DAT_O = dat_q;

endmodule

// File: tb/tb_bit2sy.sv
// Directed self-checking bench for bit2sy: QAM/QPSK packing, back-pressure and hold,
// partial-symbol flush, slot wrap with SYM_END (pilots under PILOT_INSERT_EN) and async reset.
module tb_bit2sy;

    logic       clk = 1'b0, rst = 1'b1;
    logic       cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, dat_i = 1'b0;
    logic       qam = 1'b0, qpsk = 1'b0, ack_i = 1'b0;
    logic       ack_o, cyc_o, stb_o, we_o, sym_end;
    logic [3:0] dat_o;

    int total = 0;
    int bad   = 0;

    bit2sy dut (
        .CLK_I   (clk),
        .RST_I   (rst),
        .CYC_I   (cyc_i),
        .STB_I   (stb_i),
        .WE_I    (we_i),
        .DAT_I   (dat_i),
        .ACK_O   (ack_o),
        .QAM     (qam),
        .QPSK    (qpsk),
        .CYC_O   (cyc_o),
        .STB_O   (stb_o),
        .WE_O    (we_o),
        .DAT_O   (dat_o),
        .ACK_I   (ack_i),
        .SYM_END (sym_end)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic q, input logic p);
        qam   = q;
        qpsk  = p;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = 1'b1;
    endtask

    task automatic end_burst();
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
    endtask

    // Present one bit and hold it until ACK_O, bounded.
    task automatic send_bit(input logic b, input string tag);
        logic got = 1'b0;
        dat_i = b;
        for (int n = 0; n < 30 && !got; n++) begin
            #1;
            got = ack_o;
            tick();
        end
        if (!got) chk({tag, "_ack_timeout"}, 0, 1);
    endtask

    task automatic wait_cyc_low(input string tag);
        for (int n = 0; n < 20 && cyc_o; n++) tick();
        chk(tag, int'(cyc_o), 0);
        tick();
        tick();
    endtask

    int idx, outs, ends, end_at, dj, exp_v, nbits, j;
    logic got_stb;

    initial begin
        // Reset state
        #12;
        chk("rst_stb", int'(stb_o), 0);
        chk("rst_cyc", int'(cyc_o), 0);
        chk("rst_we", int'(we_o), 0);
        chk("rst_dat", int'(dat_o), 0);
        chk("rst_ack", int'(ack_o), 0);
        chk("rst_symend", int'(sym_end), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // QAM 1,0,1,1 -> 1101, one cycle after the 4th ACK_O
        ack_i = 1'b1;
        start_burst(1'b1, 1'b0);
        #1;
        chk("t1_idle_noack", int'(ack_o), 0);
        send_bit(1'b1, "t1b0");
        send_bit(1'b0, "t1b1");
        send_bit(1'b1, "t1b2");
        chk("t1_stb_early", int'(stb_o), 0);
        send_bit(1'b1, "t1b3");
        chk("t1_stb", int'(stb_o), 1);
        chk("t1_dat", int'(dat_o), 4'b1101);
        chk("t1_cyc", int'(cyc_o), 1);
        chk("t1_we", int'(we_o), 1);
        end_burst();
        tick();
        chk("t1_stb_drop", int'(stb_o), 0);
        wait_cyc_low("t1_cyc_low");

        // QPSK 1,0,0,1 -> 0001 then 0010
        start_burst(1'b0, 1'b1);
        send_bit(1'b1, "t2b0");
        send_bit(1'b0, "t2b1");
        chk("t2_stb0", int'(stb_o), 1);
        chk("t2_dat0", int'(dat_o), 4'b0001);
        send_bit(1'b0, "t2b2");
        send_bit(1'b1, "t2b3");
        chk("t2_stb1", int'(stb_o), 1);
        chk("t2_dat1", int'(dat_o), 4'b0010);
        end_burst();
        tick();
        chk("t2_stb_drop", int'(stb_o), 0);
        wait_cyc_low("t2_cyc_low");

        // QAM with ACK_I low: 0101 on output, 0110 in hold, input stalled
        ack_i = 1'b0;
        start_burst(1'b1, 1'b0);
        send_bit(1'b1, "t3b0");
        send_bit(1'b0, "t3b1");
        send_bit(1'b1, "t3b2");
        send_bit(1'b0, "t3b3");
        send_bit(1'b0, "t3b4");
        send_bit(1'b1, "t3b5");
        send_bit(1'b1, "t3b6");
        send_bit(1'b0, "t3b7");
        chk("t3_stb", int'(stb_o), 1);
        chk("t3_dat0", int'(dat_o), 4'b0101);
        for (int n = 0; n < 3; n++) begin
            dat_i = 1'b1;
            #1;
            chk("t3_stall_ack", int'(ack_o), 0);
            chk("t3_stall_dat", int'(dat_o), 4'b0101);
            tick();
        end
        end_burst();
        ack_i = 1'b1;
        tick();
        chk("t3_stb1", int'(stb_o), 1);
        chk("t3_dat1", int'(dat_o), 4'b0110);
        tick();
        chk("t3_stb_drop", int'(stb_o), 0);
        wait_cyc_low("t3_cyc_low");

        // QAM, CYC_I drops after 6 ones -> 1111 then zero-padded 0011
        start_burst(1'b1, 1'b0);
        for (int n = 0; n < 4; n++) send_bit(1'b1, "t4a");
        chk("t4_stb0", int'(stb_o), 1);
        chk("t4_dat0", int'(dat_o), 4'b1111);
        send_bit(1'b1, "t4b4");
        send_bit(1'b1, "t4b5");
        end_burst();
        got_stb = 1'b0;
        for (int n = 0; n < 10 && !got_stb; n++) begin
            tick();
            got_stb = stb_o;
        end
        chk("t4_flush_stb", int'(got_stb), 1);
        chk("t4_flush_dat", int'(dat_o), 4'b0011);
        chk("t4_cyc_hold", int'(cyc_o), 1);
        tick();
        chk("t4_stb_drop", int'(stb_o), 0);
        chk("t4_cyc_still", int'(cyc_o), 1);
        tick();
        chk("t4_cyc_low", int'(cyc_o), 0);
        tick();

        // Streaming burst across a full OFDM symbol; data symbol j carries value j%16
`ifdef PILOT_INSERT_EN
        nbits = 192;
`else
        nbits = 208;
`endif
        idx = 0; outs = 0; ends = 0; end_at = 0; dj = 0;
        start_burst(1'b1, 1'b0);
        for (int c = 0; c < 1500; c++) begin
            if (idx >= nbits) begin
                end_burst();
            end else begin
                j     = (idx / 4) % 16;
                dat_i = 1'((j >> (idx % 4)) & 1);
            end
            #1;
            if (ack_o) idx++;
            if (stb_o) begin
`ifdef PILOT_INSERT_EN
                if (outs == 5 || outs == 19 || outs == 32 || outs == 46) begin
                    exp_v = 3;
                end else begin
                    exp_v = dj % 16;
                    dj++;
                end
`else
                exp_v = outs % 16;
`endif
                chk("t5_dat", int'(dat_o), exp_v);
                outs++;
                if (sym_end) begin
                    ends++;
                    end_at = outs;
                end
            end else if (sym_end) begin
                ends++;
            end
            if (idx >= nbits && outs > 0 && !cyc_o) break;
            tick();
        end
        tick();
        chk("t5_bits", idx, nbits);
        chk("t5_outs", outs, 52);
        chk("t5_symend_count", ends, 1);
        chk("t5_symend_pos", end_at, 52);
        tick();

        // Async reset mid-burst discards output, hold and partial symbol
        ack_i = 1'b0;
        start_burst(1'b1, 1'b0);
        for (int n = 0; n < 4; n++) send_bit(1'b1, "t6a");
        send_bit(1'b1, "t6b4");
        send_bit(1'b1, "t6b5");
        send_bit(1'b1, "t6b6");
        chk("t6_stb_pre", int'(stb_o), 1);
        end_burst();
        rst = 1'b1;
        #1;
        chk("t6_rst_stb", int'(stb_o), 0);
        chk("t6_rst_cyc", int'(cyc_o), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        ack_i = 1'b1;
        start_burst(1'b1, 1'b0);
        send_bit(1'b0, "t6c0");
        send_bit(1'b1, "t6c1");
        send_bit(1'b0, "t6c2");
        send_bit(1'b0, "t6c3");
        chk("t6_new_stb", int'(stb_o), 1);
        chk("t6_new_dat", int'(dat_o), 4'b0010);
        end_burst();
        tick();
        wait_cyc_low("t6_cyc_low");

        // No mode selected: nothing accepted, nothing emitted
        start_burst(1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("t7_ack", int'(ack_o), 0);
            tick();
        end
        chk("t7_stb", int'(stb_o), 0);
        end_burst();
        tick();
        tick();
        chk("t7_cyc", int'(cyc_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
